// File: rtl/fifo_read_checker.sv
// FIFO read-side checker: drains the FIFO under test and verifies that the
// returned words form the incrementing sequence produced by the write side.
// Reads are issued combinationally; each word is checked in the cycle after
// its read strobe. Match/error counters saturate. The first mismatch is
// captured for later inspection.
module fifo_read_checker #(
  parameter int unsigned DATA_WIDTH      = 8,
  parameter int unsigned COUNT_WIDTH     = 16,
  parameter int unsigned SEED_FROM_FIRST = 1,
  parameter int unsigned STOP_ON_ERROR   = 0
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_enable,
  input  logic                   i_clear,
  input  logic                   i_empty,
  input  logic [DATA_WIDTH-1:0]  i_data_in,
  output logic                   o_read_enable,
  output logic                   o_data_valid,
  output logic [DATA_WIDTH-1:0]  o_expected,
  output logic [COUNT_WIDTH-1:0] o_match_count,
  output logic [COUNT_WIDTH-1:0] o_error_count,
  output logic                   o_error,
  output logic [DATA_WIDTH-1:0]  o_first_error_data,
  output logic [DATA_WIDTH-1:0]  o_first_error_expected
);

  localparam logic [DATA_WIDTH-1:0]  DataOne  = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [COUNT_WIDTH-1:0] CountOne = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [COUNT_WIDTH-1:0] CountMax = '1;

  typedef enum logic [1:0] {
    StIdle,
    StSync,
    StRun,
    StHalt
  } state_e;

  state_e                 r_state;
  state_e                 w_state_next;
  logic                   r_pending;
  logic                   w_pending_next;
  logic [DATA_WIDTH-1:0]  r_expected;
  logic [DATA_WIDTH-1:0]  w_expected_next;
  logic [COUNT_WIDTH-1:0] r_match_count;
  logic [COUNT_WIDTH-1:0] w_match_count_next;
  logic [COUNT_WIDTH-1:0] r_error_count;
  logic [COUNT_WIDTH-1:0] w_error_count_next;
  logic                   r_error;
  logic                   w_error_next;
  logic [DATA_WIDTH-1:0]  r_first_error_data;
  logic [DATA_WIDTH-1:0]  w_first_error_data_next;
  logic [DATA_WIDTH-1:0]  r_first_error_expected;
  logic [DATA_WIDTH-1:0]  w_first_error_expected_next;

  logic                   w_active;
  logic                   w_consume;
  logic                   w_match;
  logic [DATA_WIDTH-1:0]  w_data_plus_one;
  logic [DATA_WIDTH-1:0]  w_expected_plus_one;
  logic [COUNT_WIDTH-1:0] w_match_count_inc;
  logic [COUNT_WIDTH-1:0] w_error_count_inc;

  // Read strobe, consume qualifier and saturating/wrapping arithmetic.
  always_comb begin
    w_active            = (r_state == StSync) || (r_state == StRun);
    // A word returned while halted is dropped, not checked.
    w_consume           = r_pending && w_active;
    w_match             = (i_data_in == r_expected);
    w_data_plus_one     = i_data_in + DataOne;
    w_expected_plus_one = r_expected + DataOne;
    w_match_count_inc   = (r_match_count == CountMax) ? r_match_count
                                                      : r_match_count + CountOne;
    w_error_count_inc   = (r_error_count == CountMax) ? r_error_count
                                                      : r_error_count + CountOne;
  end

  assign o_read_enable          = w_active && i_enable && !i_empty;
  assign o_data_valid           = w_consume;
  assign o_expected             = r_expected;
  assign o_match_count          = r_match_count;
  assign o_error_count          = r_error_count;
  assign o_error                = r_error;
  assign o_first_error_data     = r_first_error_data;
  assign o_first_error_expected = r_first_error_expected;

  // Next-state and checking datapath; clear overrides everything.
  always_comb begin
    w_state_next                = r_state;
    w_pending_next              = o_read_enable;
    w_expected_next             = r_expected;
    w_match_count_next          = r_match_count;
    w_error_count_next          = r_error_count;
    w_error_next                = r_error;
    w_first_error_data_next     = r_first_error_data;
    w_first_error_expected_next = r_first_error_expected;

    unique case (r_state)
      StIdle: begin
        if (i_enable) begin
          w_state_next = (SEED_FROM_FIRST != 0) ? StSync : StRun;
        end
      end
      StSync: begin
        if (w_consume) begin
          w_expected_next = w_data_plus_one;
          w_state_next    = StRun;
        end
      end
      StRun: begin
        if (w_consume) begin
          if (w_match) begin
            w_match_count_next = w_match_count_inc;
            w_expected_next    = w_expected_plus_one;
          end else begin
            w_error_count_next = w_error_count_inc;
            w_error_next       = 1'b1;
            if (!r_error) begin
              w_first_error_data_next     = i_data_in;
              w_first_error_expected_next = r_expected;
            end
            // Resync so a single dropped word costs exactly one error.
            w_expected_next = w_data_plus_one;
            if (STOP_ON_ERROR != 0) begin
              w_state_next = StHalt;
            end
          end
        end
      end
      StHalt: begin
        w_state_next = StHalt;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase

    if (i_clear) begin
      w_state_next                = StIdle;
      w_pending_next              = 1'b0;
      w_expected_next             = '0;
      w_match_count_next          = '0;
      w_error_count_next          = '0;
      w_error_next                = 1'b0;
      w_first_error_data_next     = '0;
      w_first_error_expected_next = '0;
    end
  end

  // FSM state register.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Datapath registers: pending read, expected word, counters, error capture.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_pending              <= 1'b0;
      r_expected             <= '0;
      r_match_count          <= '0;
      r_error_count          <= '0;
      r_error                <= 1'b0;
      r_first_error_data     <= '0;
      r_first_error_expected <= '0;
    end else begin
      r_pending              <= w_pending_next;
      r_expected             <= w_expected_next;
      r_match_count          <= w_match_count_next;
      r_error_count          <= w_error_count_next;
      r_error                <= w_error_next;
      r_first_error_data     <= w_first_error_data_next;
      r_first_error_expected <= w_first_error_expected_next;
    end
  end

endmodule

// File: doc/fifo_read_checker.md
Name: fifo_read_checker

Overview:
- Single-clock consumer that sits on the read side of the FIFO under test and drains it.
- Issues read_enable whenever the FIFO is non-empty and checking is enabled, then captures each returned word one cycle later.
- Checks that the returned words form the incrementing sequence produced by the write-side data source.
- Reports match/error counts and the first mismatch for the bench to inspect.

Parameters:
- DATA_WIDTH, default 8: width of the FIFO data word.
- COUNT_WIDTH, default 16: width of the match and error counters.
- SEED_FROM_FIRST, default 1:
  - 1: the first word read seeds the expected value.
  - 0: the expected value starts at 0.
- STOP_ON_ERROR, default 0: 1 halts reading after the first mismatch.

Ports:
- clock  input  1  read-side clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  permits issuing new reads.
- clear  input  1  synchronous clear of counters, flags and state.
- empty  input  1  FIFO empty flag, read-clock domain.
- data_in  input  DATA_WIDTH  FIFO read data, valid the cycle after read_enable.
- read_enable  output  1  FIFO read strobe.
- data_valid  output  1  high for one cycle when data_in was checked.
- expected  output  DATA_WIDTH  next expected word.
- match_count  output  COUNT_WIDTH  words matched, saturating.
- error_count  output  COUNT_WIDTH  mismatches, saturating.
- error  output  1  sticky mismatch flag.
- first_error_data  output  DATA_WIDTH  data_in at the first mismatch.
- first_error_expected  output  DATA_WIDTH  expected value at the first mismatch.

Behaviour:
- Reset (reset low, asynchronous):
  - state = IDLE.
  - All outputs and registers = 0, including the internal pending flag.
  - Reset mid-operation aborts any pending read; the returned word is not checked.
- States:
  - IDLE: go to SYNC when enable=1 and SEED_FROM_FIRST=1; go to RUN when enable=1 and SEED_FROM_FIRST=0.
  - SYNC: waits for the first returned word.
  - RUN: normal checking.
  - HALT: entered only when STOP_ON_ERROR=1.
- read_enable is combinational: (state==SYNC or RUN) and enable and !empty. It is never asserted while empty=1, and never in IDLE or HALT.
- pending <= read_enable each cycle. The cycle after pending=1, data_in is consumed and data_valid=1 for exactly that cycle.
- SYNC consume:
  - expected <= data_in+1; no compare; no counter change.
  - Next state = RUN.
- RUN consume, match (data_in==expected):
  - match_count += 1.
  - expected <= expected+1.
- RUN consume, mismatch:
  - error_count += 1; error <= 1.
  - If error was 0, capture first_error_data and first_error_expected.
  - expected <= data_in+1 (resync, so one dropped word counts as one error).
  - If STOP_ON_ERROR=1, next state = HALT.
- Arithmetic:
  - expected wraps modulo 2^DATA_WIDTH (all-ones followed by 0 is a match).
  - Counters saturate at all-ones; no wrap.
- enable deasserted mid-stream: no new reads; a read already pending is still consumed and checked in the following cycle.
- Back-to-back reads: read_enable may stay high every cycle. Throughput is one word per clock, with consume and issue in the same cycle.
- HALT: read_enable=0; counters and flags hold until clear or reset.
- clear=1 (synchronous, highest priority after reset):
  - Same values as reset on the next edge; any pending read is discarded.
  - clear takes priority over a simultaneous consume.
- empty and data_in are assumed already synchronous to clock; no internal synchronizers.

Test Plan:
1. Reset low at t=0, release, enable=0 -> read_enable=0, all counters 0, state IDLE.
2. SEED_FROM_FIRST=1; FIFO returns 0x05,0x06,0x07 on back-to-back reads -> first word seeds, match_count=2, error_count=0, expected=0x08.
3. SEED_FROM_FIRST=0; FIFO returns 0x00,0x01,0x03,0x04 -> match_count=3, error_count=1, first_error_data=0x03, first_error_expected=0x02, expected=0x05.
4. Sequence 0xFE,0xFF,0x00,0x01 -> wrap counted as matches: match_count=3 (seeded), error=0.
5. STOP_ON_ERROR=1, mismatch on third word while empty=0 -> HALT, read_enable stays 0 afterwards, error_count=1; then clear=1 -> all zero, IDLE.
6. empty toggles every cycle and enable drops with a read pending -> read_enable never high while empty=1; the pending word is still checked (data_valid=1 once) and no further reads occur.
